// File: rtl/serial_split_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_split_ctrl
// Description : Slave-side split-transaction sequencer for the bit-serial bus.
//               Holds the bus while the slave prepares read data. If the slave
//               is slow, it releases the bus through a split and later signals
//               completion to the arbiter. The total wait is bounded by a
//               timeout that produces an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_split_ctrl #(
  parameter int unsigned SPLIT_THRESH = 4,    // WAIT cycles before a split (>= 1)
  parameter int unsigned TIMEOUT      = 256   // SPLIT cycles before forced error (>= 2)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       txn_start_i,
  input  logic       txn_master_i,
  input  logic       slave_ready_i,
  input  logic       frame_done_i,
  output logic       busy_o,
  output logic       hold_o,
  output logic       split_start_o,
  output logic       split_done_o,
  output logic [1:0] split_owner_o,
  output logic       resp_valid_o,
  output logic       resp_err_o
);

  // Counter width is derived from the timeout; SPLIT_THRESH is expected to
  // stay below TIMEOUT so its terminal value fits the same counter.
  localparam int unsigned    CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] THRESH_LAST  = CNT_W'(SPLIT_THRESH - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SPLIT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       owner_q, owner_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             hold_q, hold_d;
  logic             split_start_q, split_start_d;
  logic             split_done_q, split_done_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    err_d         = err_q;
    split_start_d = 1'b0;
    split_done_d  = 1'b0;
    // Saturating increment: the counter never wraps inside one state.
    cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (txn_start_i) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          owner_d = txn_master_i ? 2'b10 : 2'b01;
          err_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        // Ready wins over the threshold in the same cycle: no split issued.
        if (slave_ready_i) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else if (cnt_q == THRESH_LAST) begin
          state_d       = ST_SPLIT;
          cnt_d         = '0;
          split_start_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SPLIT: begin
        // Ready wins over the timeout in the same cycle: no error flagged.
        if (slave_ready_i) begin
          state_d      = ST_RESP;
          cnt_d        = '0;
          split_done_d = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = ST_RESP;
          cnt_d        = '0;
          err_d        = 1'b1;
          split_done_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (frame_done_i) begin
          state_d = ST_IDLE;
          owner_d = 2'b00;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        owner_d = 2'b00;
        err_d   = 1'b0;
      end
    endcase

    // Level outputs follow the state being entered so they line up with it.
    busy_d       = (state_d != ST_IDLE);
    hold_d       = (state_d == ST_WAIT);
    resp_valid_d = (state_d == ST_RESP);
    resp_err_d   = (state_d == ST_RESP) && err_d;
  end

  // State, counter, owner/error flags and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      owner_q       <= 2'b00;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      hold_q        <= 1'b0;
      split_start_q <= 1'b0;
      split_done_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      hold_q        <= hold_d;
      split_start_q <= split_start_d;
      split_done_q  <= split_done_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign busy_o        = busy_q;
  assign hold_o        = hold_q;
  assign split_start_o = split_start_q;
  assign split_done_o  = split_done_q;
  assign split_owner_o = owner_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_err_o    = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_split_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_split_ctrl
// Description : Self-checking bench for serial_split_ctrl (SPLIT_THRESH=4,
//               TIMEOUT=16). Expected responses are queued as transactions
//               are launched and compared when the DUT presents a response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_split_ctrl;

  localparam int unsigned C_THRESH  = 4;
  localparam int unsigned C_TIMEOUT = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       txn_start_i = 1'b0;
  logic       txn_master_i = 1'b0;
  logic       slave_ready_i = 1'b0;
  logic       frame_done_i = 1'b0;
  logic       busy_o, hold_o, split_start_o, split_done_o;
  logic [1:0] split_owner_o;
  logic       resp_valid_o, resp_err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] owner;
    logic       err;
    logic       split;
  } exp_t;

  exp_t exp_q[$];

  serial_split_ctrl #(
    .SPLIT_THRESH (C_THRESH),
    .TIMEOUT      (C_TIMEOUT)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .txn_start_i   (txn_start_i),
    .txn_master_i  (txn_master_i),
    .slave_ready_i (slave_ready_i),
    .frame_done_i  (frame_done_i),
    .busy_o        (busy_o),
    .hold_o        (hold_o),
    .split_start_o (split_start_o),
    .split_done_o  (split_done_o),
    .split_owner_o (split_owner_o),
    .resp_valid_o  (resp_valid_o),
    .resp_err_o    (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge for drive/sample.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_txn(input logic m);
    txn_start_i  = 1'b1;
    txn_master_i = m;
    step();
    txn_start_i  = 1'b0;
  endtask

  task automatic finish_frame();
    frame_done_i = 1'b1;
    step();
    frame_done_i = 1'b0;
    check("idle_busy", busy_o, 0);
    check("idle_owner", split_owner_o, 2'b00);
    check("idle_err", resp_err_o, 0);
    check("idle_valid", resp_valid_o, 0);
  endtask

  // Scoreboard monitor: pop an expected response at each response start and
  // account split pulses per transaction.
  logic ss_seen = 1'b0;
  int   sd_cnt  = 0;
  logic rv_prev = 1'b0;
  logic busy_prev = 1'b0;
  logic last_split = 1'b0;

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      ss_seen   = 1'b0;
      sd_cnt    = 0;
      rv_prev   = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (split_start_o) ss_seen = 1'b1;
      if (split_done_o) sd_cnt++;
      if (split_start_o || split_done_o)
        check("start_done_excl", split_start_o & split_done_o, 0);
      if (resp_valid_o && !rv_prev) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          last_split = e.split;
          check("sb_owner", split_owner_o, e.owner);
          check("sb_err", resp_err_o, e.err);
          check("sb_split_seen", ss_seen, e.split);
          check("sb_done_at_resp", sd_cnt, e.split ? 1 : 0);
        end
      end
      if (!busy_o && busy_prev) begin
        check("sb_done_count", sd_cnt, last_split ? 1 : 0);
      end
      if (!busy_o) begin
        ss_seen = 1'b0;
        sd_cnt  = 0;
      end
      rv_prev   = resp_valid_o;
      busy_prev = busy_o;
    end
  end

  // Stimulus and cycle-exact checks
  initial begin
    exp_t e;
    // Reset state
    repeat (3) step();
    check("rst_outputs", {busy_o, hold_o, split_start_o, split_done_o,
                          split_owner_o, resp_valid_o, resp_err_o}, 0);
    rst_ni = 1'b1;
    step();
    check("post_rst_busy", busy_o, 0);

    // Fast slave, M1: ready two cycles after start, no split
    e = '{owner: 2'b10, err: 1'b0, split: 1'b0};
    exp_q.push_back(e);
    start_txn(1'b1);
    check("fast_busy", busy_o, 1);
    check("fast_hold", hold_o, 1);
    check("fast_owner", split_owner_o, 2'b10);
    step();
    slave_ready_i = 1'b1;
    step();
    check("fast_resp_valid", resp_valid_o, 1);
    check("fast_hold_off", hold_o, 0);
    check("fast_no_split", split_start_o, 0);
    check("fast_err", resp_err_o, 0);
    step();
    check("fast_resp_stays", resp_valid_o, 1);
    slave_ready_i = 1'b0;
    finish_frame();

    // Threshold split then completion 10 cycles into SPLIT, M0
    e = '{owner: 2'b01, err: 1'b0, split: 1'b1};
    exp_q.push_back(e);
    start_txn(1'b0);
    for (int i = 0; i < 4; i++) begin
      check("thr_hold", hold_o, 1);
      check("thr_no_start", split_start_o, 0);
      step();
    end
    check("thr_split_start", split_start_o, 1);
    check("thr_hold_released", hold_o, 0);
    check("thr_busy", busy_o, 1);
    step();
    check("thr_start_pulse", split_start_o, 0);
    // Robustness: a new start while busy must not disturb the owner
    txn_start_i  = 1'b1;
    txn_master_i = 1'b1;
    step();
    txn_start_i  = 1'b0;
    check("busy_start_owner", split_owner_o, 2'b01);
    check("busy_start_nostart", split_start_o, 0);
    repeat (7) step();
    check("split_not_done", resp_valid_o, 0);
    slave_ready_i = 1'b1;
    step();
    slave_ready_i = 1'b0;
    check("split_done_pulse", split_done_o, 1);
    check("split_resp_valid", resp_valid_o, 1);
    check("split_resp_err", resp_err_o, 0);
    step();
    check("split_done_single", split_done_o, 0);
    finish_frame();

    // Timeout, M1: ready never asserted
    e = '{owner: 2'b10, err: 1'b1, split: 1'b1};
    exp_q.push_back(e);
    start_txn(1'b1);
    repeat (4) step();
    check("to_split_start", split_start_o, 1);
    for (int i = 1; i < 16; i++) begin
      // A stray frame_done outside RESP is ignored
      frame_done_i = (i == 5);
      step();
      frame_done_i = 1'b0;
      if (i == 6 || i == 15) begin
        check("to_still_split", busy_o & ~resp_valid_o & ~hold_o, 1);
        check("to_no_done_yet", split_done_o, 0);
      end
    end
    step();
    check("to_done", split_done_o, 1);
    check("to_err", resp_err_o, 1);
    check("to_valid", resp_valid_o, 1);
    finish_frame();

    // Race: ready on the threshold cycle, no split
    e = '{owner: 2'b01, err: 1'b0, split: 1'b0};
    exp_q.push_back(e);
    start_txn(1'b0);
    repeat (3) step();
    slave_ready_i = 1'b1;
    step();
    slave_ready_i = 1'b0;
    check("race_thr_nostart", split_start_o, 0);
    check("race_thr_valid", resp_valid_o, 1);
    finish_frame();

    // Race: ready on the timeout cycle, no error
    e = '{owner: 2'b10, err: 1'b0, split: 1'b1};
    exp_q.push_back(e);
    start_txn(1'b1);
    repeat (4) step();
    repeat (15) step();
    check("race_to_pending", resp_valid_o, 0);
    slave_ready_i = 1'b1;
    step();
    slave_ready_i = 1'b0;
    check("race_to_done", split_done_o, 1);
    check("race_to_err", resp_err_o, 0);
    finish_frame();

    // Reset in SPLIT: outputs clear immediately, no completion pulse
    start_txn(1'b0);
    repeat (6) step();
    check("rstmid_in_split", busy_o & ~hold_o, 1);
    rst_ni = 1'b0;
    #1;
    check("rstmid_outputs", {busy_o, hold_o, split_start_o, split_done_o,
                             split_owner_o, resp_valid_o, resp_err_o}, 0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    check("rstmid_no_done", split_done_o, 0);
    check("rstmid_idle", busy_o, 0);

    repeat (2) step();
    check("sb_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the sequence is fixed-length, so this only trips on a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
